// File: rtl/logip_pkg.sv
// Shared types and constants for the host-link UART transmitter.
// find_enabled picks the lowest enabled byte lane at or above a starting index.
package logip_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int BYTES_PER_WORD = 4;

    // Returns {found, index}; lanes whose disable bit is set are skipped.
    function automatic logic [2:0] find_enabled(input logic [3:0] dis, input logic [2:0] lo);
        logic [2:0] r_res;
        r_res = 3'b000;
        for (int i = BYTES_PER_WORD - 1; i >= 0; i--) begin
            if (!dis[i] && (3'(i) >= lo)) begin
                r_res = {1'b1, 2'(i)};
            end
        end
        return r_res;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Bit-level 8N1 serialiser for a single byte.
// done_o marks the last cycle of the stop bit so a following byte can start with no gap.
module uart_tx_byte
    import logip_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       tx_o
);

    tx_state_t        r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             w_bit_end;

    assign w_bit_end = (r_baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            if (r_state != IDLE) begin
                r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (start_i) begin
                        r_state <= START;
                        r_shift <= byte_i;
                        r_tx    <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state   <= DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                STOP: begin
                    // A pending byte chains straight into its start bit.
                    if (w_bit_end) begin
                        if (start_i) begin
                            r_state <= START;
                            r_shift <= byte_i;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o = (r_state != IDLE);
    assign done_o = (r_state == STOP) && w_bit_end;
    assign tx_o   = r_tx;

endmodule

// File: rtl/uart_tx_word.sv
// Word-level UART transmitter: latches a 32-bit word and sends its enabled bytes LSB-first.
// Handshake: a word is accepted on any clock edge where stb_i=1 and rdy_o=1; otherwise stb_i is ignored.
module uart_tx_word
    import logip_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stb_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  grp_dis_i,
    output logic        rdy_o,
    output logic        tx_o
);

    logic [31:0] r_word;
    logic [3:0]  r_dis;
    logic [1:0]  r_idx;
    logic        r_rdy;
    logic        r_active;

    logic        w_accept;
    logic [2:0]  w_first;
    logic [2:0]  w_next;
    logic        w_start;
    logic [1:0]  w_sel_idx;
    logic [7:0]  w_byte;
    logic        w_busy;
    logic        w_done;
    logic        w_tx;

    assign w_accept  = stb_i && r_rdy;
    assign w_first   = find_enabled(grp_dis_i, 3'd0);
    assign w_next    = find_enabled(r_dis, {1'b0, r_idx} + 3'd1);
    // The first byte is taken straight from the inputs so its start bit follows the accept edge.
    assign w_start   = (w_accept && w_first[2]) || (r_active && w_done && w_next[2]);
    assign w_sel_idx = w_accept ? w_first[1:0] : w_next[1:0];
    assign w_byte    = w_accept ? data_i[{w_sel_idx, 3'b000} +: 8]
                                : r_word[{w_sel_idx, 3'b000} +: 8];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_word   <= '0;
            r_dis    <= '0;
            r_idx    <= '0;
            r_rdy    <= 1'b1;
            r_active <= 1'b0;
        end else if (w_accept) begin
            r_word   <= data_i;
            r_dis    <= grp_dis_i;
            r_rdy    <= 1'b0;
            r_active <= w_first[2];
            r_idx    <= w_first[2] ? w_first[1:0] : 2'd0;
        end else if (r_active && w_done) begin
            if (w_next[2]) begin
                r_idx <= w_next[1:0];
            end else begin
                r_active <= 1'b0;
                r_rdy    <= 1'b1;
            end
        end else if (!r_active && !r_rdy && !w_busy) begin
            // Fully masked word: no frame, ready again after one cycle.
            r_rdy <= 1'b1;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_byte (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (w_start),
        .byte_i  (w_byte),
        .busy_o  (w_busy),
        .done_o  (w_done),
        .tx_o    (w_tx)
    );

    assign rdy_o = r_rdy;
    assign tx_o  = w_tx;

endmodule

// File: tb/tb_uart_tx_word.sv
// Directed bench for uart_tx_word at 4 clocks per bit; a negedge monitor decodes frames
// and compares each byte against the expected queue filled when words are driven.
module tb_uart_tx_word;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        stb_i;
    logic [31:0] data_i;
    logic [3:0]  grp_dis_i;
    logic        rdy_o;
    logic        tx_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         starts_q[$];

    bit         mon_busy = 1'b0;
    int         mon_pos  = 0;
    logic [7:0] mon_byte = '0;

    always #5 clk = ~clk;

    uart_tx_word #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .stb_i     (stb_i),
        .data_i    (data_i),
        .grp_dis_i (grp_dis_i),
        .rdy_o     (rdy_o),
        .tx_o      (tx_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame decoder: offset 0 is the first start-bit cycle, data bit b sampled at 5+4b.
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (rst_i === 1'b1) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx_o === 1'b0) begin
                mon_busy = 1'b1;
                mon_pos  = 0;
                starts_q.push_back(cyc);
            end
        end else begin
            mon_pos++;
            if (mon_pos == 1) begin
                chk("start_bit", {31'd0, tx_o}, 32'd0);
            end else if (mon_pos >= 5 && mon_pos <= 33 && ((mon_pos - 5) % CPB) == 0) begin
                mon_byte[(mon_pos - 5) / CPB] = tx_o;
            end else if (mon_pos == 37) begin
                chk("stop_bit", {31'd0, tx_o}, 32'd1);
            end else if (mon_pos == FRAME - 1) begin
                e = 8'hxx;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                chk("rx_byte", {24'd0, mon_byte}, {24'd0, e});
                mon_busy = 1'b0;
            end
        end
    end

    task automatic wait_rdy();
        int g = 0;
        @(negedge clk);
        while (rdy_o !== 1'b1 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk("rdy_before_send", {31'd0, rdy_o}, 32'd1);
    endtask

    // Sends one word; glitch>0 pulses a second strobe that many cycles after accept.
    task automatic send_word(input logic [31:0] d, input logic [3:0] dis, input int glitch);
        int  k    = 0;
        int  n    = 0;
        int  lat  = 0;
        int  acc;
        bit  done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!dis[i]) begin
                exp_q.push_back(d[8*i +: 8]);
                k++;
            end
        end
        wait_rdy();
        starts_q.delete();
        stb_i     = 1'b1;
        data_i    = d;
        grp_dis_i = dis;
        @(posedge clk);
        #1;
        stb_i = 1'b0;
        acc   = cyc;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == glitch) begin
                stb_i     = 1'b1;
                data_i    = 32'hFFFF_FFFF;
                grp_dis_i = 4'b0000;
            end else if (glitch > 0 && n == glitch + 1) begin
                stb_i = 1'b0;
            end
            if (rdy_o === 1'b1) done = 1'b1;
            else lat++;
        end
        chk("rdy_low_cycles", lat, (k == 0) ? 1 : FRAME * k);
        chk("frame_count", starts_q.size(), k);
        if (starts_q.size() > 0) chk("first_start_cycle", starts_q[0], acc + 1);
        for (int i = 1; i < starts_q.size(); i++) begin
            chk("byte_spacing", starts_q[i] - starts_q[i-1], FRAME);
        end
        chk("exp_q_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int lows;
        int acc;
        int rdy_n;
        bit saw;
        bit dropped;

        rst_i     = 1'b1;
        stb_i     = 1'b0;
        data_i    = '0;
        grp_dis_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        repeat (4) @(posedge clk);

        // Reset held for 3 cycles while idle
        #1 rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", {31'd0, tx_o}, 32'd1);
        chk("reset_rdy", {31'd0, rdy_o}, 32'd1);
        rst_i = 1'b0;

        send_word(32'h1122_3344, 4'b0000, 0);
        send_word(32'hAABB_CCDD, 4'b1010, 0);
        send_word(32'hDEAD_BEEF, 4'b1111, 0);
        send_word(32'h0000_00A5, 4'b1110, 10);

        // Reset during data bit 3 of a zero byte
        wait_rdy();
        starts_q.delete();
        stb_i     = 1'b1;
        data_i    = 32'h0000_0000;
        grp_dis_i = 4'b1110;
        @(posedge clk);
        #1 stb_i = 1'b0;
        repeat (17) @(negedge clk);
        chk("bit3_low_before_reset", {31'd0, tx_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        chk("abort_tx", {31'd0, tx_o}, 32'd1);
        chk("abort_rdy", {31'd0, rdy_o}, 32'd1);
        @(negedge clk);
        rst_i = 1'b0;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_o !== 1'b1) lows++;
        end
        chk("no_low_after_abort", lows, 0);
        chk("rdy_after_abort", {31'd0, rdy_o}, 32'd1);
        chk("abort_exp_q_empty", exp_q.size(), 0);

        // Back-to-back words with stb_i held high
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        wait_rdy();
        starts_q.delete();
        stb_i     = 1'b1;
        data_i    = 32'h0000_0055;
        grp_dis_i = 4'b1110;
        @(posedge clk);
        #1 data_i = 32'h0000_00AA;
        acc     = cyc;
        n       = 0;
        rdy_n   = 0;
        saw     = 1'b0;
        dropped = 1'b0;
        while (!dropped && n < 500) begin
            @(negedge clk);
            n++;
            if (saw) begin
                stb_i   = 1'b0;
                dropped = 1'b1;
            end else if (rdy_o === 1'b1) begin
                saw   = 1'b1;
                rdy_n = n;
            end
        end
        chk("b2b_first_rdy_cycle", rdy_n, FRAME + 1);
        while (rdy_o !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_second_rdy_cycle", n, 2 * FRAME + 2);
        chk("b2b_frame_count", starts_q.size(), 2);
        if (starts_q.size() == 2) begin
            chk("b2b_first_start", starts_q[0], acc + 1);
            chk("b2b_second_start", starts_q[1], acc + FRAME + 2);
        end
        chk("b2b_exp_q_drained", exp_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
